// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: registers the execute result, runs LW/LB/LBU/SW/SB
// over a request/ready bus with timeout, and hands the writeback value to WB.
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid_ex,
  input  logic [31:0] insn_ex,
  input  logic [31:0] alu_result,
  input  logic [31:0] rt_data,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        valid_wb,
  output logic        wb_en,
  output logic [4:0]  wb_dest,
  output logic [31:0] wb_data,
  output logic        misalign_exc,
  output logic        bus_error
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;
  typedef enum logic [1:0] {K_LW, K_LB, K_LBU, K_ST} kind_t;

  // Instruction fields use big-endian numbering: insn[0:5] is bits [31:26] here.
  function automatic logic [31:0] load_ext(input kind_t k, input logic [31:0] d,
                                           input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = d[31:24];
      2'd1:    b = d[23:16];
      2'd2:    b = d[15:8];
      default: b = d[7:0];
    endcase
    case (k)
      K_LW:    return d;
      K_LB:    return {{24{b[7]}}, b};
      K_LBU:   return {24'd0, b};
      default: return 32'd0;
    endcase
  endfunction

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  kind_t            r_kind, w_kind_nxt;
  logic [1:0]       r_lane, w_lane_nxt;
  logic             r_pend_wen, w_pend_wen_nxt;
  logic             r_req, w_req_nxt;
  logic             r_we, w_we_nxt;
  logic [31:0]      r_addr, w_addr_nxt;
  logic [3:0]       r_be, w_be_nxt;
  logic [31:0]      r_wdata, w_wdata_nxt;
  logic             r_valid_wb, w_valid_nxt;
  logic             r_wb_en, w_wb_en_nxt;
  logic [4:0]       r_wb_dest, w_dest_nxt;
  logic [31:0]      r_wb_data, w_data_nxt;
  logic             r_misalign, w_mis_nxt;
  logic             r_bus_err, w_berr_nxt;

  logic [5:0]  w_op;
  logic [5:0]  w_func;
  logic        w_is_lw, w_is_lb, w_is_lbu, w_is_sw, w_is_sb;
  logic        w_is_mem, w_is_store, w_is_word, w_misaligned, w_no_wb, w_wen;
  logic [4:0]  w_dest;
  logic [1:0]  w_lane;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  kind_t       w_kind;
  logic        w_unused;

  assign w_op     = insn_ex[31:26];
  assign w_func   = insn_ex[5:0];
  assign w_unused = ^{insn_ex[25:21], insn_ex[10:6]};

  assign w_is_lw    = (w_op == 6'b100011);
  assign w_is_lb    = (w_op == 6'b100000);
  assign w_is_lbu   = (w_op == 6'b100100);
  assign w_is_sw    = (w_op == 6'b101011);
  assign w_is_sb    = (w_op == 6'b101000);
  assign w_is_mem   = w_is_lw | w_is_lb | w_is_lbu | w_is_sw | w_is_sb;
  assign w_is_store = w_is_sw | w_is_sb;
  assign w_is_word  = w_is_lw | w_is_sw;

  assign w_lane       = alu_result[1:0];
  assign w_misaligned = w_is_word && (w_lane != 2'b00);
  assign w_be         = w_is_word ? 4'b1111 : (4'b1000 >> w_lane);
  assign w_wdata      = w_is_sb ? {4{rt_data[7:0]}} : rt_data;

  always_comb begin
    w_dest = insn_ex[20:16];
    if (w_op == 6'b000000)      w_dest = insn_ex[15:11];
    else if (w_op == 6'b000011) w_dest = 5'd31;
  end

  // Stores, branches, J, JR and DIV/DIVU produce no register result.
  assign w_no_wb = w_is_store
                 || ((w_op[5:3] == 3'b000) && (w_op != 6'b000000) && (w_op != 6'b000011))
                 || (w_op == 6'b000010)
                 || ((w_op == 6'b000000) &&
                     ((w_func == 6'b011010) || (w_func == 6'b011011) || (w_func == 6'b001000)));
  assign w_wen = !w_no_wb && (w_dest != 5'd0);

  always_comb begin
    w_kind = K_ST;
    if (w_is_lw)       w_kind = K_LW;
    else if (w_is_lb)  w_kind = K_LB;
    else if (w_is_lbu) w_kind = K_LBU;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_kind_nxt     = r_kind;
    w_lane_nxt     = r_lane;
    w_pend_wen_nxt = r_pend_wen;
    w_req_nxt      = r_req;
    w_we_nxt       = r_we;
    w_addr_nxt     = r_addr;
    w_be_nxt       = r_be;
    w_wdata_nxt    = r_wdata;
    w_valid_nxt    = 1'b0;
    w_wb_en_nxt    = 1'b0;
    w_dest_nxt     = r_wb_dest;
    w_data_nxt     = r_wb_data;
    w_mis_nxt      = 1'b0;
    w_berr_nxt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (valid_ex) begin
          w_dest_nxt = w_dest;
          if (!w_is_mem) begin
            w_valid_nxt = 1'b1;
            w_wb_en_nxt = w_wen;
            w_data_nxt  = alu_result;
          end else if (w_misaligned) begin
            w_valid_nxt = 1'b1;
            w_mis_nxt   = 1'b1;
            w_data_nxt  = 32'd0;
          end else begin
            w_state_nxt    = S_ACCESS;
            w_cnt_nxt      = '0;
            w_req_nxt      = 1'b1;
            w_we_nxt       = w_is_store;
            w_addr_nxt     = {alu_result[31:2], 2'b00};
            w_be_nxt       = w_be;
            w_wdata_nxt    = w_wdata;
            w_kind_nxt     = w_kind;
            w_lane_nxt     = w_lane;
            w_pend_wen_nxt = w_wen;
          end
        end
      end
      S_ACCESS: begin
        // A ready on the limit cycle still counts as a normal completion.
        if (dmem_ready) begin
          w_state_nxt = S_IDLE;
          w_req_nxt   = 1'b0;
          w_we_nxt    = 1'b0;
          w_valid_nxt = 1'b1;
          w_wb_en_nxt = r_pend_wen;
          w_data_nxt  = load_ext(r_kind, dmem_rdata, r_lane);
        end else if (r_cnt == CNT_LIMIT) begin
          w_state_nxt = S_IDLE;
          w_req_nxt   = 1'b0;
          w_we_nxt    = 1'b0;
          w_valid_nxt = 1'b1;
          w_berr_nxt  = 1'b1;
          w_data_nxt  = 32'd0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_kind     <= K_LW;
      r_lane     <= 2'b00;
      r_pend_wen <= 1'b0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= 32'd0;
      r_be       <= 4'd0;
      r_wdata    <= 32'd0;
      r_valid_wb <= 1'b0;
      r_wb_en    <= 1'b0;
      r_wb_dest  <= 5'd0;
      r_wb_data  <= 32'd0;
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_kind     <= w_kind_nxt;
      r_lane     <= w_lane_nxt;
      r_pend_wen <= w_pend_wen_nxt;
      r_req      <= w_req_nxt;
      r_we       <= w_we_nxt;
      r_addr     <= w_addr_nxt;
      r_be       <= w_be_nxt;
      r_wdata    <= w_wdata_nxt;
      r_valid_wb <= w_valid_nxt;
      r_wb_en    <= w_wb_en_nxt;
      r_wb_dest  <= w_dest_nxt;
      r_wb_data  <= w_data_nxt;
      r_misalign <= w_mis_nxt;
      r_bus_err  <= w_berr_nxt;
    end
  end

  assign stall        = (r_state == S_ACCESS);
  assign dmem_req     = r_req;
  assign dmem_we      = r_we;
  assign dmem_addr    = r_addr;
  assign dmem_be      = r_be;
  assign dmem_wdata   = r_wdata;
  assign valid_wb     = r_valid_wb;
  assign wb_en        = r_wb_en;
  assign wb_dest      = r_wb_dest;
  assign wb_data      = r_wb_data;
  assign misalign_exc = r_misalign;
  assign bus_error    = r_bus_err;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed plan items plus randomized instructions
// checked against an arithmetic reference model of the stage.
module tb_mem_access_stage;
  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        valid_ex = 1'b0;
  logic [31:0] insn_ex = '0, alu_result = '0, rt_data = '0;
  logic        stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        valid_wb, wb_en, misalign_exc, bus_error;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;

  int n_cmp = 0;
  int n_bad = 0;

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .valid_ex(valid_ex), .insn_ex(insn_ex),
    .alu_result(alu_result), .rt_data(rt_data), .stall(stall), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .valid_wb(valid_wb), .wb_en(wb_en),
    .wb_dest(wb_dest), .wb_data(wb_data), .misalign_exc(misalign_exc), .bus_error(bus_error)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model, written from the instruction-set rules.
  function automatic int m_op(input logic [31:0] insn);
    return int'(insn >> 26);
  endfunction

  function automatic bit m_is_mem(input logic [31:0] insn);
    int op = m_op(insn);
    return op == 'h23 || op == 'h20 || op == 'h24 || op == 'h2b || op == 'h28;
  endfunction

  function automatic bit m_is_store(input logic [31:0] insn);
    return m_op(insn) == 'h2b || m_op(insn) == 'h28;
  endfunction

  function automatic bit m_is_word(input logic [31:0] insn);
    return m_op(insn) == 'h23 || m_op(insn) == 'h2b;
  endfunction

  function automatic int m_dest(input logic [31:0] insn);
    if (m_op(insn) == 0) return int'((insn >> 11) % 32);
    if (m_op(insn) == 3) return 31;
    return int'((insn >> 16) % 32);
  endfunction

  function automatic bit m_wen(input logic [31:0] insn);
    int op = m_op(insn);
    int fn = int'(insn % 64);
    bit no = m_is_store(insn) || (op < 8 && op != 0 && op != 3) || op == 2 ||
             (op == 0 && (fn == 'h1a || fn == 'h1b || fn == 'h08));
    return !no && m_dest(insn) != 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] insn, input logic [31:0] addr,
                                         input logic [31:0] rd);
    int lane = int'(addr % 4);
    int b = int'((rd >> (8 * (3 - lane))) % 256);
    case (m_op(insn))
      'h23:    return rd;
      'h20:    return (b >= 128) ? 32'(b - 256) : 32'(b);
      'h24:    return 32'(b);
      default: return 32'd0;
    endcase
  endfunction

  task automatic do_op(input logic [31:0] insn, input logic [31:0] alu, input logic [31:0] rt,
                       input int lat, input logic [31:0] rd);
    logic [31:0] exp_be, exp_wd;
    @(negedge clock);
    valid_ex = 1'b1; insn_ex = insn; alu_result = alu; rt_data = rt; dmem_ready = 1'b0;
    @(posedge clock); #1;
    valid_ex = 1'b0;
    if (!m_is_mem(insn)) begin
      chk("nm_valid", 32'(valid_wb), 1);
      chk("nm_stall", 32'(stall), 0);
      chk("nm_req", 32'(dmem_req), 0);
      chk("nm_dest", 32'(wb_dest), 32'(m_dest(insn)));
      chk("nm_wen", 32'(wb_en), 32'(m_wen(insn)));
      chk("nm_data", wb_data, alu);
      chk("nm_mis", 32'(misalign_exc), 0);
    end else if (m_is_word(insn) && alu % 4 != 0) begin
      chk("ma_valid", 32'(valid_wb), 1);
      chk("ma_exc", 32'(misalign_exc), 1);
      chk("ma_wen", 32'(wb_en), 0);
      chk("ma_req", 32'(dmem_req), 0);
      chk("ma_stall", 32'(stall), 0);
    end else begin
      exp_be = m_is_word(insn) ? 32'hF : 32'(1 << (3 - int'(alu % 4)));
      exp_wd = (m_op(insn) == 'h28) ? (rt % 256) * 32'h01010101 : rt;
      chk("acc_valid", 32'(valid_wb), 0);
      chk("acc_stall", 32'(stall), 1);
      chk("acc_req", 32'(dmem_req), 1);
      chk("acc_we", 32'(dmem_we), 32'(m_is_store(insn)));
      chk("acc_addr", dmem_addr, alu - alu % 4);
      chk("acc_be", 32'(dmem_be), exp_be);
      if (m_is_store(insn)) chk("acc_wdata", dmem_wdata, exp_wd);
      // Upstream keeps offering an instruction; it must not be captured while stalled.
      valid_ex = 1'b1; insn_ex = (32'd7 << 11) | 32'h21; alu_result = 32'hDEAD0000;
      for (int k = 0; k < TO; k++) begin
        dmem_ready = (k == lat);
        dmem_rdata = (k == lat) ? rd : $urandom;
        @(posedge clock); #1;
        dmem_ready = 1'b0;
        if (k == lat) begin
          chk("done_valid", 32'(valid_wb), 1);
          chk("done_data", wb_data, m_load(insn, alu, rd));
          chk("done_wen", 32'(wb_en), 32'(m_wen(insn)));
          chk("done_dest", 32'(wb_dest), 32'(m_dest(insn)));
          chk("done_berr", 32'(bus_error), 0);
          chk("done_stall", 32'(stall), 0);
          chk("done_req", 32'(dmem_req), 0);
          break;
        end else if (k == TO - 1) begin
          chk("to_valid", 32'(valid_wb), 1);
          chk("to_berr", 32'(bus_error), 1);
          chk("to_wen", 32'(wb_en), 0);
          chk("to_stall", 32'(stall), 0);
          chk("to_req", 32'(dmem_req), 0);
        end else begin
          chk("wait_valid", 32'(valid_wb), 0);
          chk("wait_stall", 32'(stall), 1);
          chk("wait_req", 32'(dmem_req), 1);
          chk("wait_addr", dmem_addr, alu - alu % 4);
        end
      end
      valid_ex = 1'b0;
    end
  endtask

  logic [31:0] addu5, lw_i, op_tab[13];
  logic [31:0] r_insn, r_alu;
  logic [5:0]  r_op;
  logic [5:0]  fn_tab[5];

  initial begin
    addu5 = (32'd5 << 11) | 32'h21;
    lw_i  = (32'h23 << 26) | (32'd9 << 16);
    op_tab = '{32'h00, 32'h00, 32'h03, 32'h02, 32'h04, 32'h05, 32'h08, 32'h0f,
               32'h23, 32'h20, 32'h24, 32'h2b, 32'h28};
    fn_tab = '{6'h21, 6'h1a, 6'h1b, 6'h08, 6'h23};

    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", 32'(valid_wb), 0);
    chk("rst_req", 32'(dmem_req), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_data", wb_data, 0);
    chk("rst_addr", dmem_addr, 0);
    @(negedge clock); reset = 1'b0;

    do_op(addu5, 32'h7, 32'h0, 0, 32'h0);
    do_op(addu5, 32'h8, 32'h0, 0, 32'h0);
    do_op((32'h20 << 26) | (32'd8 << 16), 32'h102, 32'h0, 3, 32'h1122F344);
    do_op((32'h24 << 26) | (32'd8 << 16), 32'h102, 32'h0, 3, 32'h1122F344);
    do_op((32'h28 << 26) | (32'd4 << 16), 32'h3, 32'hABCDEF5A, 0, 32'h0);
    do_op(lw_i, 32'h6, 32'h0, 0, 32'h0);
    do_op(lw_i, 32'h40, 32'h0, TO, 32'h0);
    do_op(addu5, 32'h1234, 32'h0, 0, 32'h0);
    do_op(32'h0C00_0000, 32'h4444, 32'h0, 0, 32'h0);

    @(negedge clock);
    valid_ex = 1'b0; insn_ex = addu5; dmem_ready = 1'b1; dmem_rdata = $urandom;
    @(posedge clock); #1;
    dmem_ready = 1'b0;
    chk("idle_novalid", 32'(valid_wb), 0);
    chk("idle_stall", 32'(stall), 0);

    @(negedge clock);
    valid_ex = 1'b1; insn_ex = lw_i; alu_result = 32'h80;
    @(posedge clock); #1;
    valid_ex = 1'b0;
    chk("pre_rst_req", 32'(dmem_req), 1);
    #2 reset = 1'b1;
    #1;
    chk("async_req", 32'(dmem_req), 0);
    chk("async_stall", 32'(stall), 0);
    chk("async_valid", 32'(valid_wb), 0);
    @(negedge clock); reset = 1'b0;
    do_op(lw_i, 32'h80, 32'h0, 1, 32'hCAFEBABE);

    for (int i = 0; i < 60; i++) begin
      r_op = op_tab[$urandom_range(0, 12)][5:0];
      r_insn = {r_op, 5'($urandom), 5'($urandom), 5'($urandom), 5'd0,
                fn_tab[$urandom_range(0, 4)]};
      r_alu = $urandom;
      if ((r_op == 6'h23 || r_op == 6'h2b) && $urandom_range(0, 3) != 0) r_alu[1:0] = 2'b00;
      do_op(r_insn, r_alu, $urandom, $urandom_range(0, TO), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Registers the execute result and performs data-memory access for LW/LB/LBU/SW/SB over a variable-latency request/ready bus.
- Presents the writeback value and destination register to the writeback stage.
- Stalls upstream while a memory access is outstanding, and flags misaligned or timed-out accesses.

Parameters:
- TIMEOUT, 16, max cycles in ACCESS waiting for dmem_ready before aborting with bus_error; must be >= 1.

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high reset
- valid_ex  in  1  execute stage holds a valid instruction
- insn_ex  in  32  instruction in execute, big-endian bit numbering [0:31]
- alu_result  in  32  execute data_out (effective address for loads/stores, result otherwise)
- rt_data  in  32  rt register value (store data)
- stall  out  1  upstream must hold; combinational, high iff state==ACCESS
- dmem_req  out  1  memory request, registered
- dmem_we  out  1  write enable, registered
- dmem_addr  out  32  word-aligned address (low two bits forced 0)
- dmem_be  out  4  byte enables; be[0] = bits [0:7] (most significant byte)
- dmem_wdata  out  32  store data
- dmem_ready  in  1  request completed; rdata valid the same cycle
- dmem_rdata  in  32  read data
- valid_wb  out  1  one-cycle pulse: wb outputs valid
- wb_en  out  1  register write required
- wb_dest  out  5  destination register
- wb_data  out  32  writeback value
- misalign_exc  out  1  one-cycle pulse with valid_wb on a misaligned word access
- bus_error  out  1  one-cycle pulse with valid_wb on timeout

Behaviour:
- Reset (asynchronous, mid-operation included):
  - state=IDLE, all outputs 0, timeout counter 0.
  - An outstanding request is dropped; dmem_req falls immediately.
- Capture: at a posedge with valid_ex=1 and stall=0.
- Decode of captured insn:
  - opcode = insn[0:5].
  - 100011 LW, 100000 LB, 100100 LBU, 101011 SW, 101000 SB are memory ops.
  - Everything else is non-memory.
- Destination:
  - opcode 000000 uses rd = insn[16:20].
  - 000011 (JAL) uses 31.
  - Otherwise rt = insn[11:15].
  - wb_en=0 for SW, SB, branches (opcode[0:2]==000 except 000000/000011), J (000010), and for opcode 000000 with func 011010/011011 (DIV/DIVU) or 001000 (JR).
  - wb_en=0 whenever wb_dest==0.
- Non-memory op: next cycle valid_wb=1, wb_data=alu_result. Latency 1; back-to-back capture every cycle is allowed.
- Memory op, aligned (words: addr[30:31]==00; bytes: always aligned):
  - Next cycle: state=ACCESS, dmem_req=1, dmem_addr={addr[0:29],00}, dmem_we=store.
  - Byte enables: LW/SW be=1111; LB/LBU/SB be one-hot at lane addr[30:31] (00->1000, 11->0001).
  - SB: dmem_wdata = rt_data[24:31] replicated to all 4 lanes. SW: dmem_wdata = rt_data.
  - Request stays stable until completion.
- In ACCESS, posedge with dmem_ready=1:
  - dmem_req<=0, state<=IDLE, valid_wb<=1.
  - LW: wb_data = rdata.
  - LB: selected lane, sign-extended. LBU: selected lane, zero-extended.
  - Stores: wb_data = 0.
  - Minimum memory-op latency: 2 cycles after capture.
- Timeout:
  - The counter increments every ACCESS cycle without ready.
  - When it reaches TIMEOUT without ready: abort, dmem_req<=0, IDLE, valid_wb=1, wb_en=0, bus_error=1.
  - dmem_ready arriving in the same cycle as the limit wins: normal completion.
- Misaligned LW/SW:
  - No bus request is made.
  - Next cycle: valid_wb=1, wb_en=0, misalign_exc=1, state stays IDLE.
- Stall and capture:
  - stall is high throughout ACCESS, including the completion cycle, so no capture happens on the completing edge.
  - The next instruction is captured on the following edge.
- valid_ex=0 at capture: next cycle valid_wb=0.
- misalign_exc and bus_error are only ever high together with valid_wb.
- dmem_ready outside ACCESS is ignored.

Test Plan:
- ADDU (op 000000, rd=5, func 100001), alu_result=0x00000007 -> next cycle valid_wb=1, wb_dest=5, wb_en=1, wb_data=0x7, stall never high.
- LB, addr 0x00000102, dmem_ready high 3 cycles after req, rdata=0x1122F344:
  - During wait: dmem_be=0010, dmem_addr=0x100, stall high.
  - At completion: wb_data=0xFFFFFFF3.
  - LBU with the same access -> wb_data=0x000000F3.
- SB, addr 0x3, rt_data=0xABCDEF5A -> dmem_we=1, be=0001, wdata=0x5A5A5A5A, wb_en=0.
- LW, addr 0x00000006 -> no dmem_req, valid_wb=1 with misalign_exc=1, wb_en=0.
- LW with TIMEOUT=4 and dmem_ready never asserted -> after 4 ACCESS cycles bus_error=1 with valid_wb=1; the following ADDU is captured the next edge.
- Reset asserted mid-ACCESS -> dmem_req, stall and valid_wb drop immediately (asynchronously); after release, an LW completes normally.
